// File: rtl/varint_stream_decode.sv
// Two-stage AXI-Stream LEB128 varint decoder. S1 finds the terminator and masks payload groups.
// S2 assembles the value, byte count and error flag, and drives the m_axis outputs.
module varint_stream_decode #(
    parameter int unsigned MAX_BYTES    = 10,
    parameter int unsigned UINT_BITS    = 64,
    parameter int unsigned ENCODED_BITS = MAX_BYTES * 8,
    parameter int unsigned TUSER_BITS   = $clog2(MAX_BYTES + 1),
    parameter int unsigned ZIGZAG       = 0
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [ENCODED_BITS-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [UINT_BITS-1:0]    m_axis_tdata,
    output logic [TUSER_BITS-1:0]   m_axis_tuser,
    output logic                    m_axis_terror,
    output logic [31:0]             stat_decoded,
    output logic [31:0]             stat_errors
);

    localparam int unsigned GroupBits = 7 * MAX_BYTES;

    // Decode (combinational front of S1)
    logic [GroupBits-1:0]  dec_grp;
    logic [TUSER_BITS-1:0] dec_cnt;
    logic                  dec_found;
    logic                  dec_ovf;

    always_comb begin
        dec_grp   = '0;
        dec_cnt   = '0;
        dec_found = 1'b0;
        dec_ovf   = 1'b0;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (!dec_found) begin
                dec_grp[7*i +: 7] = s_axis_tdata[8*i +: 7];
                if (!s_axis_tdata[8*i+7]) begin
                    dec_found = 1'b1;
                    dec_cnt   = TUSER_BITS'(i + 1);
                end
            end
        end
        // Groups past the terminator are already zero, so any set bit here is overflow.
        for (int p = int'(UINT_BITS); p < int'(GroupBits); p++) begin
            dec_ovf = dec_ovf | dec_grp[p];
        end
    end

    // Stage registers
    logic                  s1_vld_q, s1_vld_d;
    logic [UINT_BITS-1:0]  s1_val_q, s1_val_d;
    logic [TUSER_BITS-1:0] s1_cnt_q, s1_cnt_d;
    logic                  s1_unterm_q, s1_unterm_d;
    logic                  s1_ovf_q, s1_ovf_d;

    logic                  s2_vld_q, s2_vld_d;
    logic [UINT_BITS-1:0]  s2_val_q, s2_val_d;
    logic [TUSER_BITS-1:0] s2_cnt_q, s2_cnt_d;
    logic                  s2_err_q, s2_err_d;

    logic [31:0]           stat_dec_q, stat_dec_d;
    logic [31:0]           stat_err_q, stat_err_d;

    logic                  s2_load;
    logic                  s1_load;
    logic                  m_hs;
    logic [UINT_BITS-1:0]  asm_val;

    always_comb begin
        s2_load = !s2_vld_q || m_axis_tready;
        // Gated by reset so the slave side never advertises ready while held in reset.
        s1_load = aresetn && (!s1_vld_q || s2_load);
        m_hs    = s2_vld_q && m_axis_tready;
    end

    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_val_d    = s1_val_q;
        s1_cnt_d    = s1_cnt_q;
        s1_unterm_d = s1_unterm_q;
        s1_ovf_d    = s1_ovf_q;
        if (s1_load) begin
            s1_vld_d = s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_val_d    = dec_grp[UINT_BITS-1:0];
                s1_cnt_d    = dec_cnt;
                s1_unterm_d = !dec_found;
                s1_ovf_d    = dec_ovf;
            end
        end
    end

    always_comb begin
        asm_val = s1_val_q;
        if (ZIGZAG != 0) begin
            asm_val = s1_val_q[0] ? ~(s1_val_q >> 1) : (s1_val_q >> 1);
        end

        s2_vld_d = s2_vld_q;
        s2_val_d = s2_val_q;
        s2_cnt_d = s2_cnt_q;
        s2_err_d = s2_err_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                if (s1_unterm_q) begin
                    s2_val_d = '0;
                    s2_cnt_d = '0;
                    s2_err_d = 1'b1;
                end else begin
                    s2_val_d = asm_val;
                    s2_cnt_d = s1_cnt_q;
                    s2_err_d = s1_ovf_q;
                end
            end
        end
    end

    always_comb begin
        stat_dec_d = stat_dec_q;
        stat_err_d = stat_err_q;
        if (m_hs) begin
            if (s2_err_q) begin
                if (stat_err_q != 32'hFFFF_FFFF) stat_err_d = stat_err_q + 32'd1;
            end else begin
                if (stat_dec_q != 32'hFFFF_FFFF) stat_dec_d = stat_dec_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_vld_q    <= 1'b0;
            s1_val_q    <= '0;
            s1_cnt_q    <= '0;
            s1_unterm_q <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_val_q    <= '0;
            s2_cnt_q    <= '0;
            s2_err_q    <= 1'b0;
            stat_dec_q  <= '0;
            stat_err_q  <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_val_q    <= s1_val_d;
            s1_cnt_q    <= s1_cnt_d;
            s1_unterm_q <= s1_unterm_d;
            s1_ovf_q    <= s1_ovf_d;
            s2_vld_q    <= s2_vld_d;
            s2_val_q    <= s2_val_d;
            s2_cnt_q    <= s2_cnt_d;
            s2_err_q    <= s2_err_d;
            stat_dec_q  <= stat_dec_d;
            stat_err_q  <= stat_err_d;
        end
    end

    assign s_axis_tready = s1_load;
    assign m_axis_tvalid = s2_vld_q;
    assign m_axis_tdata  = s2_val_q;
    assign m_axis_tuser  = s2_cnt_q;
    assign m_axis_terror = s2_err_q;
    assign stat_decoded  = stat_dec_q;
    assign stat_errors   = stat_err_q;

endmodule

// File: tb/tb_varint_stream_decode.sv
// Directed bench for varint_stream_decode: plain and zigzag instances, backpressure and
// mid-stream reset.
module tb_varint_stream_decode;

    logic        clk;
    logic        aresetn;

    logic        s_tvalid, s_tready;
    logic [79:0] s_tdata;
    logic        m_tvalid, m_tready, m_terror;
    logic [63:0] m_tdata;
    logic [3:0]  m_tuser;
    logic [31:0] st_dec, st_err;

    logic        z_s_tvalid, z_s_tready;
    logic [79:0] z_s_tdata;
    logic        z_m_tvalid, z_m_terror;
    logic [63:0] z_m_tdata;
    logic [3:0]  z_m_tuser;
    logic [31:0] z_st_dec, z_st_err;

    int n_checks = 0;
    int n_fail   = 0;

    varint_stream_decode #(.ZIGZAG(0)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_terror (m_terror),
        .stat_decoded  (st_dec),
        .stat_errors   (st_err)
    );

    varint_stream_decode #(.ZIGZAG(1)) dut_zz (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tvalid (z_s_tvalid),
        .s_axis_tready (z_s_tready),
        .s_axis_tdata  (z_s_tdata),
        .m_axis_tvalid (z_m_tvalid),
        .m_axis_tready (1'b1),
        .m_axis_tdata  (z_m_tdata),
        .m_axis_tuser  (z_m_tuser),
        .m_axis_terror (z_m_terror),
        .stat_decoded  (z_st_dec),
        .stat_errors   (z_st_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes one word, then waits until its result sits in S2.
    task automatic run_one(input logic [79:0] w);
        s_tdata  = w;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        tick();
    endtask

    initial begin
        int          cyc;
        int          sent;
        int          got;
        int          occ;
        logic        prev_stall;
        logic [63:0] prev_data;

        aresetn    = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        m_tready   = 1'b1;
        z_s_tvalid = 1'b0;
        z_s_tdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_terror", m_terror, 0);
        check("rst_stat_decoded", st_dec, 0);
        check("rst_stat_errors", st_err, 0);
        aresetn = 1'b1;
        #1;
        check("post_rst_s_tready", s_tready, 1);
        tick();

        // 1 then 300, back to back
        s_tdata  = 80'h01;
        s_tvalid = 1'b1;
        tick();
        s_tdata = 80'h02AC;
        check("lat_not_yet", m_tvalid, 0);
        tick();
        s_tvalid = 1'b0;
        check("d1_valid", m_tvalid, 1);
        check("d1_tdata", m_tdata, 1);
        check("d1_tuser", m_tuser, 1);
        check("d1_terror", m_terror, 0);
        tick();
        check("d300_valid", m_tvalid, 1);
        check("d300_tdata", m_tdata, 300);
        check("d300_tuser", m_tuser, 2);
        check("d300_terror", m_terror, 0);
        tick();
        check("d300_drained", m_tvalid, 0);
        check("d300_stat_decoded", st_dec, 2);

        // Largest 64-bit value
        run_one(80'h01FF_FFFF_FFFF_FFFF_FFFF);
        check("max_valid", m_tvalid, 1);
        check("max_tdata", m_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("max_tuser", m_tuser, 10);
        check("max_terror", m_terror, 0);
        tick();
        check("max_stat_decoded", st_dec, 3);

        // Overflow: bit 64 set, value truncated
        run_one(80'h02FF_FFFF_FFFF_FFFF_FFFF);
        check("ovf_tdata", m_tdata, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ovf_tuser", m_tuser, 10);
        check("ovf_terror", m_terror, 1);
        tick();
        check("ovf_stat_errors", st_err, 1);
        check("ovf_stat_decoded", st_dec, 3);

        // Unterminated
        run_one(80'h8080_8080_8080_8080_8080);
        check("unt_tdata", m_tdata, 0);
        check("unt_tuser", m_tuser, 0);
        check("unt_terror", m_terror, 1);
        tick();
        check("unt_stat_errors", st_err, 2);
        check("unt_stat_decoded", st_dec, 3);

        // Backpressure: tready 0,0,0,1 repeating
        cyc        = 0;
        sent       = 0;
        got        = 0;
        occ        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (got < 6 && cyc < 60) begin
            m_tready = (cyc % 4 == 3);
            s_tvalid = (sent < 6);
            s_tdata  = 80'(sent + 1);
            #1;
            check("bp_s_tready", s_tready, (occ == 2 && !m_tready) ? 0 : 1);
            if (prev_stall) begin
                check("bp_hold_valid", m_tvalid, 1);
                check("bp_stable", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                check("bp_order", m_tdata, 64'(got + 1));
                got++;
                occ--;
            end
            if (s_tvalid && s_tready) begin
                sent++;
                occ++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            cyc++;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        check("bp_count", 64'(got), 6);
        check("bp_drained", m_tvalid, 0);
        check("bp_stat_decoded", st_dec, 9);

        // Zigzag instance: 3, 4, 1 back to back
        z_s_tdata  = 80'h03;
        z_s_tvalid = 1'b1;
        tick();
        z_s_tdata = 80'h04;
        tick();
        z_s_tdata = 80'h01;
        check("zz3_valid", z_m_tvalid, 1);
        check("zz3_tdata", z_m_tdata, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        z_s_tvalid = 1'b0;
        check("zz4_tdata", z_m_tdata, 2);
        check("zz4_tuser", z_m_tuser, 1);
        tick();
        check("zz1_tdata", z_m_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("zz1_terror", z_m_terror, 0);
        tick();
        check("zz_stat_decoded", z_st_dec, 3);

        // Reset with two words in flight
        s_tdata  = 80'h05;
        s_tvalid = 1'b1;
        tick();
        s_tdata = 80'h07;
        tick();
        s_tvalid = 1'b0;
        check("mid_pre_valid", m_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("mid_async_valid", m_tvalid, 0);
        check("mid_s_tready", s_tready, 0);
        check("mid_stat_decoded", st_dec, 0);
        check("mid_stat_errors", st_err, 0);
        tick();
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", m_tvalid, 0);
        end
        check("mid_end_stat_decoded", st_dec, 0);
        check("mid_end_stat_errors", st_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
